// File: rtl/wb_write_arbiter.sv
// Register-file write-port front end: arbitrates two writeback sources into an
// in-order FIFO, drains one write per cycle and exports a pending-destination map.
module wb_write_arbiter #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5,
    parameter int REG_COUNT = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_s0_valid,
    output logic                         o_s0_ready,
    input  logic [REG_ADDRW-1:0]         i_s0_addr,
    input  logic [CPU_WIDTH-1:0]         i_s0_data,
    input  logic                         i_s1_valid,
    output logic                         o_s1_ready,
    input  logic [REG_ADDRW-1:0]         i_s1_addr,
    input  logic [CPU_WIDTH-1:0]         i_s1_data,
    input  logic                         i_stall,
    output logic                         o_wen,
    output logic [REG_ADDRW-1:0]         o_waddr,
    output logic [CPU_WIDTH-1:0]         o_wdata,
    output logic [REG_COUNT-1:0]         o_pend,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [CNTW-1:0]      count_q, count_d, free;
    logic [PTRW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, wptr_s1;
    logic [DEPTH-1:0]     vld_q, vld_d;
    logic [REG_ADDRW-1:0] addr_q [DEPTH];
    logic [REG_ADDRW-1:0] addr_d [DEPTH];
    logic [CPU_WIDTH-1:0] data_q [DEPTH];
    logic [CPU_WIDTH-1:0] data_d [DEPTH];
    logic                 wen_q, wen_d;
    logic [REG_ADDRW-1:0] waddr_q, waddr_d;
    logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
    logic                 s0_ready, s1_ready, s0_push, s1_push, pop;
    logic [REG_COUNT-1:0] pend_c;

    // Readiness uses only the registered occupancy; a same-cycle pop earns no credit.
    always_comb begin
        free     = CNTW'(DEPTH) - count_q;
        s0_ready = !i_rst && (free >= CNTW'(1));
        s1_ready = !i_rst && (i_s0_valid ? (free >= CNTW'(2)) : (free >= CNTW'(1)));
        s0_push  = i_s0_valid && s0_ready && (i_s0_addr != '0);
        s1_push  = i_s1_valid && s1_ready && (i_s1_addr != '0);
        pop      = (count_q != '0) && !i_stall;
    end

    always_comb begin
        vld_d   = vld_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wptr_s1 = wptr_q + PTRW'(s0_push);
        if (pop) begin
            vld_d[rptr_q] = 1'b0;
        end
        if (s0_push) begin
            vld_d[wptr_q]  = 1'b1;
            addr_d[wptr_q] = i_s0_addr;
            data_d[wptr_q] = i_s0_data;
        end
        // src1 lands behind src0 when both are accepted together.
        if (s1_push) begin
            vld_d[wptr_s1]  = 1'b1;
            addr_d[wptr_s1] = i_s1_addr;
            data_d[wptr_s1] = i_s1_data;
        end
        wptr_d  = wptr_s1 + PTRW'(s1_push);
        rptr_d  = rptr_q + PTRW'(pop);
        count_d = count_q + CNTW'(s0_push) + CNTW'(s1_push) - CNTW'(pop);
        wen_d   = pop;
        waddr_d = pop ? addr_q[rptr_q] : waddr_q;
        wdata_d = pop ? data_q[rptr_q] : wdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            vld_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            vld_q   <= vld_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Entry payloads are qualified by vld_q, so they need no reset.
    always_ff @(posedge i_clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_comb begin
        pend_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pend_c = pend_c | (REG_COUNT'(1) << addr_q[i]);
            end
        end
        if (wen_q) begin
            pend_c = pend_c | (REG_COUNT'(1) << waddr_q);
        end
    end

    assign o_s0_ready = s0_ready;
    assign o_s1_ready = s1_ready;
    assign o_wen      = wen_q;
    assign o_waddr    = waddr_q;
    assign o_wdata    = wdata_q;
    assign o_pend     = pend_c;
    assign o_count    = count_q;
    assign o_empty    = (count_q == '0) && !wen_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_write_arbiter;

    localparam int CPU_WIDTH = 64;
    localparam int REG_ADDRW = 5;
    localparam int REG_COUNT = 32;
    localparam int DEPTH     = 4;
    localparam int CNTW      = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s0v, s1v, stall;
    logic                 s0_ready, s1_ready;
    logic [REG_ADDRW-1:0] s0a, s1a;
    logic [CPU_WIDTH-1:0] s0d, s1d;
    logic                 wen, empty;
    logic [REG_ADDRW-1:0] waddr;
    logic [CPU_WIDTH-1:0] wdata;
    logic [REG_COUNT-1:0] pend;
    logic [CNTW-1:0]      count;

    always #5 clk = ~clk;

    wb_write_arbiter #(
        .CPU_WIDTH(CPU_WIDTH), .REG_ADDRW(REG_ADDRW),
        .REG_COUNT(REG_COUNT), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_s0_valid(s0v), .o_s0_ready(s0_ready), .i_s0_addr(s0a), .i_s0_data(s0d),
        .i_s1_valid(s1v), .o_s1_ready(s1_ready), .i_s1_addr(s1a), .i_s1_data(s1d),
        .i_stall(stall),
        .o_wen(wen), .o_waddr(waddr), .o_wdata(wdata),
        .o_pend(pend), .o_count(count), .o_empty(empty)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        logic [REG_ADDRW-1:0] a;
        logic [CPU_WIDTH-1:0] d;
    } ent_t;

    ent_t                 mq[$];
    logic                 m_wen   = 1'b0;
    logic [REG_ADDRW-1:0] m_waddr = '0;
    logic [CPU_WIDTH-1:0] m_wdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REG_COUNT-1:0] model_pend();
        logic [REG_COUNT-1:0] p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (m_wen) p[m_waddr] = 1'b1;
        return p;
    endfunction

    // Reference model: queue of accepted writes plus a one-entry output stage.
    always @(posedge clk) begin : model
        int   free;
        bit   r0, r1;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            free = DEPTH - mq.size();
            r0   = (free >= 1);
            r1   = s0v ? (free >= 2) : (free >= 1);
            if (mq.size() > 0 && !stall) begin
                e       = mq.pop_front();
                m_wen   = 1'b1;
                m_waddr = e.a;
                m_wdata = e.d;
            end else begin
                m_wen = 1'b0;
            end
            if (s0v && r0 && s0a != 0) begin
                e.a = s0a; e.d = s0d; mq.push_back(e);
            end
            if (s1v && r1 && s1a != 0) begin
                e.a = s1a; e.d = s1d; mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        int free;
        if (chk_en) begin
            free = DEPTH - mq.size();
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_wen",   64'(wen),   64'(m_wen));
            chk("m_waddr", 64'(waddr), 64'(m_waddr));
            chk("m_wdata", wdata, m_wdata);
            chk("m_pend",  64'(pend),  64'(model_pend()));
            chk("m_empty", 64'(empty), 64'((mq.size() == 0) && !m_wen));
            chk("m_s0_ready", 64'(s0_ready), 64'(!rst && free >= 1));
            chk("m_s1_ready", 64'(s1_ready), 64'(!rst && (s0v ? free >= 2 : free >= 1)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        s0v = 1'b0;
        s1v = 1'b0;
    endtask

    initial begin
        int exp_a[4];
        rst = 1'b1; stall = 1'b0;
        s0v = 1'b0; s0a = '0; s0d = '0;
        s1v = 1'b0; s1a = '0; s1d = '0;
        tick();
        chk_en = 1'b1;
        chk("rst_wen",   64'(wen), 0);
        chk("rst_waddr", 64'(waddr), 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pend",  64'(pend), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_s0_ready", 64'(s0_ready), 0);
        chk("rst_s1_ready", 64'(s1_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_s0_ready", 64'(s0_ready), 1);
        chk("post_rst_s1_ready", 64'(s1_ready), 1);

        // Single write: visible on the write port two cycles after acceptance.
        s0v = 1'b1; s0a = 5; s0d = 64'h1234;
        #1 chk("single_s0_ready", 64'(s0_ready), 1);
        tick(); idle();
        chk("single_q_wen",  64'(wen), 0);
        chk("single_q_pend", 64'(pend), 64'h20);
        tick();
        chk("single_wen",   64'(wen), 1);
        chk("single_waddr", 64'(waddr), 5);
        chk("single_wdata", wdata, 64'h1234);
        chk("single_pend",  64'(pend), 64'h20);
        tick();
        chk("single_done_wen",  64'(wen), 0);
        chk("single_done_pend", 64'(pend), 0);

        // Dual accept: src0 drains before src1.
        s0v = 1'b1; s0a = 3; s0d = 64'hA;
        s1v = 1'b1; s1a = 4; s1d = 64'hB;
        #1;
        chk("dual_s0_ready", 64'(s0_ready), 1);
        chk("dual_s1_ready", 64'(s1_ready), 1);
        tick(); idle();
        chk("dual_count", 64'(count), 2);
        tick();
        chk("dual_w0_addr", 64'(waddr), 3);
        chk("dual_w0_data", wdata, 64'hA);
        tick();
        chk("dual_w1_wen",  64'(wen), 1);
        chk("dual_w1_addr", 64'(waddr), 4);
        chk("dual_w1_data", wdata, 64'hB);
        tick();
        chk("dual_idle_wen", 64'(wen), 0);

        // Fill under stall and backpressure at the free=1 boundary.
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s1v = 1'b1; s1a = REG_ADDRW'(i); s1d = 64'h100 + 64'(i);
            #1 chk("fill_s1_ready", 64'(s1_ready), 1);
            tick();
        end
        idle();
        #1;
        chk("full_count",    64'(count), 4);
        chk("full_s0_ready", 64'(s0_ready), 0);
        chk("full_s1_ready", 64'(s1_ready), 0);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        chk("fill_pop_addr",  64'(waddr), 1);
        chk("fill_pop_count", 64'(count), 3);
        s0v = 1'b1; s0a = 9;  s0d = 64'h99;
        s1v = 1'b1; s1a = 10; s1d = 64'hAA;
        #1;
        chk("free1_s0_ready", 64'(s0_ready), 1);
        chk("free1_s1_ready", 64'(s1_ready), 0);
        tick(); idle(); stall = 1'b0;
        chk("refill_count", 64'(count), 4);
        exp_a = '{2, 3, 4, 9};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_wen",  64'(wen), 1);
            chk("drain_addr", 64'(waddr), 64'(exp_a[i]));
        end
        tick();
        chk("drain_empty", 64'(empty), 1);

        // Writes to x0 handshake but never enter the queue.
        s0v = 1'b1; s0a = 0; s0d = 64'hFF;
        #1 chk("x0_s0_ready", 64'(s0_ready), 1);
        tick(); idle();
        chk("x0_count", 64'(count), 0);
        chk("x0_pend",  64'(pend), 0);
        chk("x0_wen",   64'(wen), 0);
        tick();
        chk("x0_wen_late", 64'(wen), 0);
        chk("x0_empty",    64'(empty), 1);

        // Duplicate destination keeps its pending bit until the last write.
        s0v = 1'b1; s0a = 7; s0d = 64'h1;
        tick();
        s0d = 64'h2;
        tick(); idle();
        chk("dup_first_data", wdata, 64'h1);
        chk("dup_first_pend", 64'(pend), 64'h80);
        tick();
        chk("dup_last_data", wdata, 64'h2);
        chk("dup_last_pend", 64'(pend), 64'h80);
        tick();
        chk("dup_clear_pend",  64'(pend), 0);
        chk("dup_hold_wdata",  wdata, 64'h2);
        chk("dup_hold_waddr",  64'(waddr), 7);

        // Reset while draining discards queue and output stage.
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s1v = 1'b1; s1a = REG_ADDRW'(11 + i); s1d = 64'h200 + 64'(i);
            tick();
        end
        idle(); stall = 1'b0;
        tick();
        chk("mid_wen",   64'(wen), 1);
        chk("mid_addr",  64'(waddr), 11);
        chk("mid_count", 64'(count), 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_s0_ready", 64'(s0_ready), 0);
        chk("mid_rst_s1_ready", 64'(s1_ready), 0);
        tick();
        rst = 1'b0;
        chk("mid_rst_wen",   64'(wen), 0);
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_pend",  64'(pend), 0);
        chk("mid_rst_empty", 64'(empty), 1);
        #1;
        chk("mid_rel_s0_ready", 64'(s0_ready), 1);
        chk("mid_rel_s1_ready", 64'(s1_ready), 1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer-side front end for the integer register file write port (one write per cycle).
- Merges register writeback requests from two producers: src0 (ALU path, higher priority) and src1 (LSU/multi-cycle path). Each producer uses a valid/ready handshake.
- Queues accepted requests in an in-order FIFO and drains them into the register file write port.
- Exports a pending-destination bitmap that decode uses for RAW hazard interlock.

Parameters:
- CPU_WIDTH, 64, data width of a register write.
- REG_ADDRW, 5, register address width.
- REG_COUNT, 32, number of architectural registers; width of o_pend.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_s0_valid  in  1  src0 write request.
- o_s0_ready  out  1  src0 accept.
- i_s0_addr  in  REG_ADDRW  src0 destination register.
- i_s0_data  in  CPU_WIDTH  src0 write data.
- i_s1_valid  in  1  src1 write request.
- o_s1_ready  out  1  src1 accept.
- i_s1_addr  in  REG_ADDRW  src1 destination register.
- i_s1_data  in  CPU_WIDTH  src1 write data.
- i_stall  in  1  write port unavailable this cycle; blocks pop.
- o_wen  out  1  register file write enable (registered).
- o_waddr  out  REG_ADDRW  register file write address (registered).
- o_wdata  out  CPU_WIDTH  register file write data (registered).
- o_pend  out  REG_COUNT  bit r=1 while any queued or output-stage write targets register r.
- o_count  out  clog2(DEPTH+1)  FIFO occupancy.
- o_empty  out  1  FIFO and output stage both idle.

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - All state resets synchronously on i_rst=1.
  - Reset values: count=0, pointers=0, all entries invalid; o_wen=0, o_waddr=0, o_wdata=0; o_pend=0; o_empty=1.
  - o_s0_ready and o_s1_ready are forced 0 while i_rst=1.
- Accept rules:
  - free = DEPTH − count, using the registered count only. No credit is given for a same-cycle pop.
  - o_s0_ready = (free ≥ 1).
  - o_s1_ready = (free ≥ 2) if i_s0_valid, else (free ≥ 1).
  - A handshake completes when valid && ready. Both sources may complete in the same cycle.
  - Ready may depend on the other source's valid, but never on its own valid.
- Ordering:
  - Simultaneous accepts enqueue src0 at wptr and src1 at wptr+1.
  - FIFO drain order equals accept order.
- x0 handling: a request with addr==0 completes its handshake but is not enqueued, does not consume space, and never sets o_pend[0].
- Pop / output stage:
  - Pop occurs when count>0 && !i_stall.
  - On pop, at the clock edge: o_wen←1, o_waddr/o_wdata←head entry, rptr advances.
  - Otherwise o_wen←0, and o_waddr/o_wdata hold their previous values.
- Latency: a request accepted in cycle N (empty queue, no stall) gives o_wen=1 in cycle N+2. The register file commits at the end of N+2.
- Simultaneous push and pop: count_next = count + pushes − pop. Range is 0..DEPTH.
- Pointers wrap modulo DEPTH.
- o_pend:
  - Combinational from state only: OR over valid FIFO entries of onehot(addr), plus onehot(o_waddr) when o_wen=1.
  - A bit clears the cycle after the final write to that register has appeared on o_wen.
  - Duplicate destinations in the queue keep the bit set until the last one drains.
- o_empty = (count==0) && !o_wen.
- Stall:
  - i_stall affects only pop.
  - Accept continues until full.
  - A stalled cycle produces o_wen=0 in the following cycle. Data are never lost or reordered.
- Reset mid-operation: queued entries and the output stage are discarded. Pending writes are dropped; the pipeline flush owner re-issues them.

Test Plan:
- Single write: reset, then s0 valid addr=5 data=0x1234 for one cycle → o_s0_ready=1; o_wen=1, o_waddr=5, o_wdata=0x1234 exactly 2 cycles later; o_pend[5]=1 for those 2 cycles, then 0.
- Dual accept: s0 (addr=3, 0xA) and s1 (addr=4, 0xB) in the same cycle with an empty queue → both ready; o_wen sequence in consecutive cycles is addr 3/0xA, then addr 4/0xB; o_count peaks at 2.
- Fill and backpressure: i_stall=1, push 4 src1 writes (addr 1..4) → o_count=4, both readies 0. Then, with count=3 and both valid, o_s0_ready=1 and o_s1_ready=0. Release stall → 4 writes drain in order, one per cycle.
- x0 discard: s0 addr=0 data=0xFF → handshake completes, o_count stays 0, o_wen never asserted, o_pend=0.
- Duplicate destination: two writes to addr=7 (0x1, then 0x2) → o_pend[7] stays 1 until the cycle after the 0x2 write; final o_wdata=0x2.
- Reset mid-drain: 3 entries queued, assert i_rst for 1 cycle → next cycle o_wen=0, o_count=0, o_pend=0, o_empty=1; readies return to 1 after reset deasserts.
